// File: rtl/pixel_stream_pkg.sv
// Shared state encoding and frame-size constants for the pixel output path
// between the pooled-output FIFO and the bit-serial port.
package pixel_stream_pkg;

  localparam int PIX_62X62 = 3844;
  localparam int PIX_61X61 = 3721;
  localparam int PIX_31X31 = 961;

  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_STALL_LIMIT = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } stream_state_e;

endpackage

// File: rtl/pixel_stream_if.sv
// FIFO read port and bit-serial valid/ready port of the pixel sequencer.
// The master side is the sequencer; the slave side is the FIFO plus sink.
interface pixel_stream_if
  import pixel_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              serial_data;
  logic              serial_valid;
  logic              serial_ready_in;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  serial_ready_in,
    output fifo_rd_en,
    output serial_data,
    output serial_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output serial_ready_in,
    input  fifo_rd_en,
    input  serial_data,
    input  serial_valid
  );

endinterface

// File: rtl/pixel_bit_serializer.sv
// Shifts one byte out MSB-first over a per-bit valid/ready handshake.
// A load on the same cycle as the last accept keeps valid high with no bubble.
module pixel_bit_serializer
  import pixel_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              ready_i,
  output logic              data_o,
  output logic              valid_o,
  output logic              byte_done_o
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;
  logic              accept;
  logic              last_bit;

  assign accept      = valid_q && ready_i;
  assign last_bit    = (idx_q == LAST_IDX);
  assign byte_done_o = accept && last_bit;

  // Data only moves on an accepted bit, so a stalled sink sees a stable bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q <= load_data_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (accept) begin
      if (last_bit) begin
        valid_q <= 1'b0;
      end else begin
        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

  assign data_o  = shift_q[DATA_W-1];
  assign valid_o = valid_q;

endmodule

// File: rtl/pixel_stream_ctrl.sv
// Frame sequencer: reads exactly PIXEL_CNT bytes from the output FIFO and
// streams them bit-serially, reporting progress, completion and starvation.
module pixel_stream_ctrl
  import pixel_stream_pkg::*;
#(
  parameter int  PIXEL_CNT   = PIX_31X31,
  parameter int  DATA_W      = DEFAULT_DATA_W,
  parameter int  STALL_LIMIT = DEFAULT_STALL_LIMIT,
  localparam int CNT_W       = $clog2(PIXEL_CNT + 1)
) (
  input  logic             clk_200mhz,
  input  logic             reset,
  input  logic             start_i,
  input  logic             wr_rst_busy_i,
  input  logic             rd_rst_busy_i,
  pixel_stream_if.master   bus,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             stall_err_o,
  output logic [CNT_W-1:0] pixel_count_o
);

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(PIXEL_CNT);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  stream_state_e      state_q;
  logic [DATA_W-1:0]  hold_q;
  logic               hold_valid_q;
  logic               rd_pending_q;
  logic [CNT_W-1:0]   issued_q;
  logic [CNT_W-1:0]   sent_q;
  logic [CNT_W-1:0]   sent_d;
  logic [STALL_W-1:0] stall_cnt_q;
  logic               stall_err_q;
  logic               frame_done_q;

  logic rst_busy;
  logic active;
  logic rd_en;
  logic byte_done;
  logic last_byte;
  logic load;
  logic starving;

  assign rst_busy  = wr_rst_busy_i || rd_rst_busy_i;
  assign active    = (state_q == FETCH) || (state_q == SHIFT);
  assign sent_d    = sent_q + 1'b1;
  assign last_byte = (state_q == SHIFT) && byte_done && (sent_d == FRAME_LEN);

  // Only one byte is ever in flight between the FIFO and the hold register.
  assign rd_en = active && !hold_valid_q && !rd_pending_q && !bus.fifo_empty
                 && (issued_q < FRAME_LEN) && !rst_busy;

  assign load = hold_valid_q &&
                ((state_q == FETCH) ||
                 ((state_q == SHIFT) && byte_done && !last_byte));

  assign starving = (state_q == FETCH) && !hold_valid_q && !rd_pending_q && !rd_en;

  always_ff @(posedge clk_200mhz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      rd_pending_q <= 1'b0;
      issued_q     <= '0;
      sent_q       <= '0;
      stall_cnt_q  <= '0;
      stall_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      rd_pending_q <= rd_en;

      if (rd_en) begin
        issued_q <= issued_q + 1'b1;
      end

      if (rd_pending_q) begin
        hold_q       <= bus.fifo_dout;
        hold_valid_q <= 1'b1;
      end else if (load) begin
        hold_valid_q <= 1'b0;
      end

      // Starvation never aborts the frame; it only raises the sticky flag.
      if (rd_en) begin
        stall_cnt_q <= '0;
      end else if (starving && (stall_cnt_q != STALL_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
        if (stall_cnt_q == STALL_MAX - 1'b1) begin
          stall_err_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (start_i && !rst_busy) begin
            state_q     <= FETCH;
            issued_q    <= '0;
            sent_q      <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
          end
        end
        FETCH: begin
          if (hold_valid_q) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (byte_done) begin
            sent_q <= sent_d;
            if (last_byte) begin
              state_q      <= DONE;
              frame_done_q <= 1'b1;
            end else if (!hold_valid_q) begin
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          if (!start_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pixel_bit_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk         (clk_200mhz),
    .rst         (reset),
    .load_i      (load),
    .load_data_i (hold_q),
    .ready_i     (bus.serial_ready_in),
    .data_o      (bus.serial_data),
    .valid_o     (bus.serial_valid),
    .byte_done_o (byte_done)
  );

  assign bus.fifo_rd_en = rd_en;
  assign busy_o         = (state_q != IDLE);
  assign frame_done_o   = frame_done_q;
  assign stall_err_o    = stall_err_q;
  assign pixel_count_o  = sent_q;

endmodule
